// File: rtl/jts16_layer_mux.sv
// Layer priority mixer: resolves N layer pixels into one palette index plus shadow strobe,
// with blanking kept aligned to the two-stage pipeline and a per-frame win counter for debug.
module jts16_layer_mux #(
    parameter int          LAYERS   = 4,
    parameter int          PXLW     = 11,
    parameter int          PRIOW    = 2,
    parameter int unsigned BG_COLOR = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pxl_cen,
    input  logic [LAYERS*PXLW-1:0]  lyr_pxl,
    input  logic [LAYERS*PRIOW-1:0] lyr_prio,
    input  logic [LAYERS-1:0]       lyr_shd,
    input  logic [LAYERS-1:0]       lyr_en,
    input  logic                    solo_en,
    input  logic [2:0]              solo_sel,
    input  logic                    preLHBL,
    input  logic                    preLVBL,
    input  logic [2:0]              st_sel,
    output logic [PXLW-1:0]         pal_addr,
    output logic                    shadow,
    output logic                    LHBL,
    output logic                    LVBL,
    output logic [15:0]             st_count
);

    // Stage 1 state
    logic [LAYERS-1:0]       col_q, col_d;
    logic [LAYERS-1:0]       shc_q, shc_d;
    logic [LAYERS*PRIOW-1:0] prio_q;
    logic [LAYERS*PXLW-1:0]  pxl_q;
    logic                    hbl_q, vbl_q;

    // Stage 2 state
    logic [PXLW-1:0]         pal_q, pal_d;
    logic                    shadow_q, shadow_d;
    logic                    lhbl_q, lvbl_q;

    // Hit counter
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             st_count_q, st_count_d;

    // Winner resolution over stage-1 registers
    logic                    win_vld;
    logic [2:0]              win_idx;
    logic [PRIOW-1:0]        win_prio;
    logic [PXLW-1:0]         win_pxl;
    logic                    shd_hit;
    logic                    active;
    logic                    lvbl_fall;

    always_comb begin
        col_d = '0;
        shc_d = '0;
        for (int unsigned k = 0; k < LAYERS; k++) begin
            if (lyr_pxl[k*PXLW +: 4] != 4'd0 && lyr_en[k] &&
                (!solo_en || solo_sel == 3'(k))) begin
                col_d[k] = !lyr_shd[k];
                shc_d[k] =  lyr_shd[k];
            end
        end
    end

    // Ascending scan with >= lets the higher index take priority ties.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        win_prio = '0;
        win_pxl  = PXLW'(BG_COLOR);
        for (int unsigned k = 0; k < LAYERS; k++) begin
            if (col_q[k] && prio_q[k*PRIOW +: PRIOW] >= win_prio) begin
                win_vld  = 1'b1;
                win_idx  = 3'(k);
                win_prio = prio_q[k*PRIOW +: PRIOW];
                win_pxl  = pxl_q[k*PXLW +: PXLW];
            end
        end
    end

    always_comb begin
        shd_hit = 1'b0;
        for (int unsigned k = 0; k < LAYERS; k++) begin
            if (shc_q[k] && prio_q[k*PRIOW +: PRIOW] >= win_prio) begin
                shd_hit = 1'b1;
            end
        end
    end

    assign active    = hbl_q && vbl_q;
    assign lvbl_fall = lvbl_q && !vbl_q;

    always_comb begin
        pal_d    = active ? win_pxl : '0;
        shadow_d = active && shd_hit;
    end

    // st_sel outside the layer range can never match win_idx, so it never counts.
    always_comb begin
        cnt_d      = cnt_q;
        st_count_d = st_count_q;
        if (lvbl_fall) begin
            st_count_d = cnt_q;
            cnt_d      = '0;
        end else if (active && win_vld && win_idx == st_sel && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            shc_q      <= '0;
            prio_q     <= '0;
            pxl_q      <= '0;
            hbl_q      <= 1'b0;
            vbl_q      <= 1'b0;
            pal_q      <= '0;
            shadow_q   <= 1'b0;
            lhbl_q     <= 1'b0;
            lvbl_q     <= 1'b0;
            cnt_q      <= '0;
            st_count_q <= '0;
        end else if (pxl_cen) begin
            col_q      <= col_d;
            shc_q      <= shc_d;
            prio_q     <= lyr_prio;
            pxl_q      <= lyr_pxl;
            hbl_q      <= preLHBL;
            vbl_q      <= preLVBL;
            pal_q      <= pal_d;
            shadow_q   <= shadow_d;
            lhbl_q     <= hbl_q;
            lvbl_q     <= vbl_q;
            cnt_q      <= cnt_d;
            st_count_q <= st_count_d;
        end
    end

    assign pal_addr = pal_q;
    assign shadow   = shadow_q;
    assign LHBL     = lhbl_q;
    assign LVBL     = lvbl_q;
    assign st_count = st_count_q;

endmodule

// File: tb/tb_jts16_layer_mux.sv
// Self-checking bench for jts16_layer_mux: directed vector table, blank/counter sequences
// and randomized traffic compared against a behavioural priority model.
module tb_jts16_layer_mux;

    localparam int          L  = 4;
    localparam int          W  = 11;
    localparam int          P  = 2;
    localparam logic [10:0] BG = 11'h7F0;

    logic             clk = 1'b0;
    logic             rst;
    logic             pxl_cen;
    logic [L*W-1:0]   lyr_pxl;
    logic [L*P-1:0]   lyr_prio;
    logic [L-1:0]     lyr_shd, lyr_en;
    logic             solo_en;
    logic [2:0]       solo_sel;
    logic             preLHBL, preLVBL;
    logic [2:0]       st_sel;
    logic [W-1:0]     pal_addr;
    logic             shadow, LHBL, LVBL;
    logic [15:0]      st_count;

    jts16_layer_mux #(.LAYERS(L), .PXLW(W), .PRIOW(P), .BG_COLOR(32'h7F0)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .lyr_pxl(lyr_pxl), .lyr_prio(lyr_prio), .lyr_shd(lyr_shd), .lyr_en(lyr_en),
        .solo_en(solo_en), .solo_sel(solo_sel),
        .preLHBL(preLHBL), .preLVBL(preLVBL), .st_sel(st_sel),
        .pal_addr(pal_addr), .shadow(shadow), .LHBL(LHBL), .LVBL(LVBL), .st_count(st_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [10:0] pal;
        logic        shd;
        logic        hb;
        logic        vb;
        int          win;
    } res_t;

    typedef struct {
        logic [3:0][10:0] pxl;
        logic [3:0][1:0]  prio;
        logic [3:0]       shd;
        logic [3:0]       en;
        logic             solo_en;
        logic [2:0]       solo_sel;
        logic [10:0]      exp_pal;
        logic             exp_shd;
    } vec_t;

    vec_t vecs[$];
    res_t pend, outx;
    int   cnt;
    logic [15:0] st_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: find the top colour priority, then the highest layer holding it.
    function automatic res_t model();
        res_t r;
        int maxp, wp;
        logic op;
        logic [10:0] px;
        int pr;
        maxp = -1;
        r.win = -1;
        r.shd = 1'b0;
        for (int k = 0; k < L; k++) begin
            px = lyr_pxl[k*W +: W];
            pr = int'(lyr_prio[k*P +: P]);
            op = (px[3:0] != 4'd0) && lyr_en[k] && (!solo_en || int'(solo_sel) == k);
            if (op && !lyr_shd[k] && pr > maxp) maxp = pr;
        end
        for (int k = 0; k < L; k++) begin
            px = lyr_pxl[k*W +: W];
            pr = int'(lyr_prio[k*P +: P]);
            op = (px[3:0] != 4'd0) && lyr_en[k] && (!solo_en || int'(solo_sel) == k);
            if (op && !lyr_shd[k] && pr == maxp) r.win = k;
        end
        wp = (r.win < 0) ? 0 : maxp;
        for (int k = 0; k < L; k++) begin
            px = lyr_pxl[k*W +: W];
            pr = int'(lyr_prio[k*P +: P]);
            op = (px[3:0] != 4'd0) && lyr_en[k] && (!solo_en || int'(solo_sel) == k);
            if (op && lyr_shd[k] && pr >= wp) r.shd = 1'b1;
        end
        r.pal = (r.win < 0) ? BG : lyr_pxl[r.win*W +: W];
        r.hb = preLHBL;
        r.vb = preLVBL;
        if (!preLHBL || !preLVBL) begin
            r.pal = '0;
            r.shd = 1'b0;
        end
        return r;
    endfunction

    task automatic model_reset();
        pend   = '{pal: '0, shd: 1'b0, hb: 1'b0, vb: 1'b0, win: -1};
        outx   = pend;
        cnt    = 0;
        st_exp = '0;
    endtask

    task automatic tick(input bit cen);
        res_t cur;
        cur = model();
        pxl_cen = cen;
        @(posedge clk);
        #1;
        if (cen) begin
            if (outx.vb && !pend.vb) begin
                st_exp = 16'(cnt);
                cnt = 0;
            end else if (pend.hb && pend.vb && pend.win == int'(st_sel)) begin
                cnt = (cnt >= 65535) ? 65535 : cnt + 1;
            end
            outx = pend;
            pend = cur;
        end
        chk("tick", {2'b00, pal_addr, shadow, LHBL, LVBL, st_count},
                    {2'b00, outx.pal, outx.shd, outx.hb, outx.vb, st_exp});
    endtask

    function automatic vec_t mk(input logic [43:0] pxl, input logic [7:0] prio,
                                input logic [3:0] shd, input logic [3:0] en,
                                input logic se, input logic [2:0] ss,
                                input logic [10:0] ep, input logic es);
        vec_t v;
        v.pxl = pxl; v.prio = prio; v.shd = shd; v.en = en;
        v.solo_en = se; v.solo_sel = ss; v.exp_pal = ep; v.exp_shd = es;
        return v;
    endfunction

    task automatic set_vec(input vec_t v);
        lyr_pxl = v.pxl; lyr_prio = v.prio; lyr_shd = v.shd; lyr_en = v.en;
        solo_en = v.solo_en; solo_sel = v.solo_sel;
    endtask

    task automatic run_ticks(input int n, input logic hb, input logic vb);
        preLHBL = hb;
        preLVBL = vb;
        for (int i = 0; i < n; i++) tick(1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        int nlow, first_low;
        vec_t vwin2;

        rst = 1'b1; pxl_cen = 1'b0; lyr_pxl = '0; lyr_prio = '0; lyr_shd = '0; lyr_en = '0;
        solo_en = 1'b0; solo_sel = '0; preLHBL = 1'b0; preLVBL = 1'b0; st_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {2'b00, pal_addr, shadow, LHBL, LVBL, st_count}, 32'd0);
        rst = 1'b0;

        // Directed vectors: pixels layer3..0, priorities layer3..0
        vecs.push_back(mk({11'h044, 11'h033, 11'h022, 11'h011}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'hF, 0, 0, 11'h044, 0));
        vecs.push_back(mk({11'h040, 11'h033, 11'h022, 11'h011}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'hF, 0, 0, 11'h033, 0));
        vecs.push_back(mk({11'h044, 11'h033, 11'h022, 11'h011}, {2'd1, 2'd2, 2'd2, 2'd0}, 4'b0000, 4'hF, 0, 0, 11'h033, 0));
        vecs.push_back(mk({11'h040, 11'h030, 11'h020, 11'h010}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'hF, 0, 0, BG, 0));
        vecs.push_back(mk({11'h044, 11'h000, 11'h022, 11'h000}, {2'd3, 2'd0, 2'd1, 2'd0}, 4'b1000, 4'hF, 0, 0, 11'h022, 1));
        vecs.push_back(mk({11'h044, 11'h000, 11'h022, 11'h000}, {2'd0, 2'd0, 2'd1, 2'd0}, 4'b1000, 4'hF, 0, 0, 11'h022, 0));
        vecs.push_back(mk({11'h044, 11'h033, 11'h022, 11'h011}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'hF, 1, 1, 11'h022, 0));
        vecs.push_back(mk({11'h044, 11'h033, 11'h022, 11'h011}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'hF, 1, 5, BG, 0));
        vecs.push_back(mk({11'h044, 11'h033, 11'h022, 11'h011}, {2'd3, 2'd2, 2'd1, 2'd0}, 4'b0000, 4'h7, 0, 0, 11'h033, 0));
        vecs.push_back(mk({11'h000, 11'h000, 11'h000, 11'h015}, {2'd0, 2'd0, 2'd0, 2'd0}, 4'b0001, 4'hF, 0, 0, BG, 1));
        vecs.push_back(mk({11'h04F, 11'h033, 11'h022, 11'h7A1}, {2'd3, 2'd1, 2'd1, 2'd3}, 4'b0000, 4'hF, 0, 0, 11'h04F, 0));
        vecs.push_back(mk({11'h04F, 11'h033, 11'h022, 11'h7A1}, {2'd3, 2'd1, 2'd1, 2'd3}, 4'b0000, 4'h7, 0, 0, 11'h7A1, 0));

        preLHBL = 1'b1;
        preLVBL = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            set_vec(vecs[i]);
            tick(1);
            tick(0);
            tick(1);
            chk($sformatf("vec%0d", i), {20'd0, pal_addr, shadow}, {20'd0, vecs[i].exp_pal, vecs[i].exp_shd});
        end

        // Blank alignment: 10 low input ticks must show as exactly 10 low output ticks, 2 later
        set_vec(vecs[4]);
        run_ticks(4, 1, 1);
        nlow = 0;
        first_low = -1;
        for (int i = 0; i < 15; i++) begin
            preLHBL = (i >= 10);
            tick(1);
            if (!LHBL) begin
                nlow++;
                if (first_low < 0) first_low = i;
                chk("blank_out", {20'd0, pal_addr, shadow}, 32'd0);
            end
        end
        chk("blank_len", 32'(nlow), 32'd10);
        chk("blank_start", 32'(first_low), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rnd = {$urandom, $urandom};
            lyr_pxl  = rnd[43:0];
            lyr_prio = 8'($urandom);
            lyr_shd  = 4'($urandom) & 4'($urandom);
            lyr_en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            solo_en  = ($urandom_range(0, 7) == 0);
            solo_sel = 3'($urandom);
            preLHBL  = ($urandom_range(0, 9) != 0);
            preLVBL  = ($urandom_range(0, 29) != 0);
            if (i % 100 == 0) st_sel = 3'($urandom);
            tick($urandom_range(0, 3) != 0);
        end

        // Counter: layer 2 always wins, full 320x224 frame saturates
        vwin2 = mk({11'h044, 11'h033, 11'h022, 11'h011}, {2'd2, 2'd3, 2'd1, 2'd0}, 4'b0000, 4'hF, 0, 0, 11'h033, 0);
        set_vec(vwin2);
        st_sel = 3'd2;
        run_ticks(4, 1, 0);
        for (int r = 0; r < 224; r++) begin
            run_ticks(320, 1, 1);
            run_ticks(2, 0, 1);
        end
        run_ticks(4, 1, 0);
        chk("cnt_sat", 32'(st_count), 32'h0000FFFF);

        // 1000 winning pixels followed by 200 where layer 3 takes the tie
        run_ticks(1000, 1, 1);
        lyr_prio = {2'd3, 2'd3, 2'd1, 2'd0};
        run_ticks(200, 1, 1);
        run_ticks(4, 1, 0);
        chk("cnt_1000", 32'(st_count), 32'd1000);

        // Out-of-range st_sel never counts
        set_vec(vwin2);
        st_sel = 3'd5;
        run_ticks(50, 1, 1);
        run_ticks(4, 1, 0);
        chk("cnt_sel_oob", 32'(st_count), 32'd0);

        // Reset mid-frame, then a partial frame of 20 winning pixels
        st_sel = 3'd2;
        run_ticks(50, 1, 1);
        run_ticks(4, 1, 0);
        chk("cnt_pre_rst", 32'(st_count), 32'd50);
        run_ticks(30, 1, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid", {2'b00, pal_addr, shadow, LHBL, LVBL, st_count}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        preLHBL = 1'b1;
        preLVBL = 1'b1;
        tick(1);
        chk("rst_blank1", {30'd0, LHBL, LVBL}, 32'd0);
        tick(1);
        chk("rst_blank2", {30'd0, LHBL, LVBL}, 32'd3);
        run_ticks(18, 1, 1);
        run_ticks(4, 1, 0);
        chk("cnt_partial", 32'(st_count), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jts16_layer_mux.md
# jts16_layer_mux

Parametrised layer priority mixer for the System 16 / Out Run video chain. It takes N tile/sprite/road layer pixels, each with a priority and a shadow flag, and resolves them into one palette address plus a shadow strobe. It also delays blanking to stay aligned with the palette address. It sits between the layer generators and the palette/colour-mix stage, and generalises the fixed tilemap+object mixing to any layer count. Two debug features are included: a solo-layer mode and a per-frame pixel-hit counter.

## Interface
Parameters:
- LAYERS, 4, number of input layers (2..8); layer 0 is lowest index
- PXLW, 11, palette index width per layer
- PRIOW, 2, priority width per layer
- BG_COLOR, 0, palette index output when no layer is opaque

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- pxl_cen  in  1  pixel clock enable; all state advances only when high
- lyr_pxl  in  LAYERS*PXLW  packed layer pixels, layer k at [k*PXLW +: PXLW]
- lyr_prio  in  LAYERS*PRIOW  packed priorities, layer k at [k*PRIOW +: PRIOW]
- lyr_shd  in  LAYERS  per-layer shadow flag
- lyr_en  in  LAYERS  per-layer enable (gfx_en style debug mask)
- solo_en  in  1  solo mode enable
- solo_sel  in  3  layer shown in solo mode
- preLHBL  in  1  horizontal blank, active low, input timing
- preLVBL  in  1  vertical blank, active low, input timing
- st_sel  in  3  layer whose win count is reported
- pal_addr  out  PXLW  resolved palette index
- shadow  out  1  shadow applies to the current pal_addr
- LHBL  out  1  preLHBL delayed to match pal_addr
- LVBL  out  1  preLVBL delayed to match pal_addr
- st_count  out  16  win count of layer st_sel over the last full frame

## Operation
- Opaque: a layer is opaque when lyr_pxl[k][3:0] != 0 and lyr_en[k]=1.
- Solo mode: only layer solo_sel may be opaque. If solo_sel >= LAYERS, no layer is opaque.
- Candidates: an opaque layer with lyr_shd[k]=0 is a colour candidate. An opaque layer with lyr_shd[k]=1 is a shadow candidate.
- Winner selection:
  - The winner is the colour candidate with the highest priority.
  - On equal priority, the higher layer index wins.
  - If there are no colour candidates, pal_addr = BG_COLOR with an effective winner priority of 0.
- Shadow: shadow=1 when any shadow candidate has priority >= the winner priority. A shadow candidate never changes pal_addr.
- Blanking: while the delayed LHBL=0 or LVBL=0, pal_addr=0 and shadow=0. Winner computation and counting are suppressed during blanking.
- Hit counter:
  - One 16-bit counter runs for the layer selected by st_sel, sampled at stage 1.
  - It increments on each active pixel (pxl_cen, delayed blanks both high) where that layer is the winner.
  - It saturates at 0xFFFF.
  - On the falling edge of the delayed LVBL, the counter value is copied to st_count and the counter clears to 0.
  - A change of st_sel mid-frame takes effect immediately. That frame's count is then mixed; this is accepted.
- st_sel >= LAYERS: the counter never increments.

## Timing
- Two-stage pipeline, both stages gated by pxl_cen:
  - Stage 1 registers the opaque/candidate vectors, priorities, pixels and blanks.
  - Stage 2 registers pal_addr, shadow, LHBL and LVBL.
- Latency: inputs sampled at pxl_cen tick n appear on the outputs after tick n+1. LHBL and LVBL carry exactly the same 2-tick delay.
- With pxl_cen low, all outputs and the counter hold their values.
- Reset values (asynchronous, immediate):
  - pal_addr=0, shadow=0, LHBL=0, LVBL=0, st_count=0
  - counter=0, all pipeline registers 0
- Reset mid-frame: after release, outputs stay blanked until two pxl_cen ticks have passed with preLHBL/preLVBL high. The first st_count latch reflects only the partial frame.
- Priority comparison is unsigned on PRIOW bits. Latency is fixed and independent of LAYERS.

## Test plan
- Basic priority, LAYERS=4: layer pixels 0x011/0x022/0x033/0x044 with priorities 0/1/2/3, all enabled, blanks high -> pal_addr=0x044 two ticks later. Then layer 3 pixel=0x040 (transparent) -> pal_addr=0x033.
- Tie and background: layers 1 and 2 both at priority 2 with opaque pixels -> pal_addr equals layer 2's pixel. All pixels with low nibble 0 -> pal_addr=BG_COLOR.
- Shadow:
  - Layer 3 opaque, lyr_shd=1, prio 3, over layer 1 with prio 1 -> pal_addr = layer 1 pixel, shadow=1.
  - Shadow layer prio 0 over a prio-1 winner -> shadow=0.
- Solo and enable mask:
  - solo_en=1, solo_sel=1 -> only layer 1 is shown.
  - solo_sel=5 -> BG_COLOR.
  - lyr_en=4'b0111 with layer 3 top -> layer 2 shown.
- Blank alignment: toggle preLHBL low for 10 ticks -> LHBL low for exactly 10 ticks starting 2 ticks later, with pal_addr=0 and shadow=0 throughout.
- Counter:
  - Frame of 320x224 active pixels with layer 2 always winning, st_sel=2 -> st_count=71680 saturated to 0xFFFF after the LVBL fall.
  - Frame with 1000 winning pixels -> st_count=1000.
  - Assert rst mid-frame -> st_count=0 immediately.
